// File: rtl/pu_sequencer.sv
// pu_sequencer: issues one operand tuple per cycle to a fixed-latency PU,
// follows each tuple down the pipeline with a tag shift register, and sums
// the 12-bit results into a saturating accumulator.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; acc_out/ovf hold the previous job result
//   ISSUE | mem_rd high, one tuple per cycle, mem_addr = issue counter
//   DRAIN | no issue; waiting for the last tagged result to be summed
//   DONE  | one-cycle done pulse, final acc_out valid
module pu_sequencer #(
    parameter int ADDR_W = 6,
    parameter int ACC_W  = 16,
    parameter int PU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       pu_out,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [PU_LAT-1:0] tag_q;
    logic              start_ok;
    logic              last_issue;
    logic              last_result;
    logic [ACC_W:0]    sum;

    assign start_ok    = (state_q == IDLE) && start;
    assign last_issue  = (cnt_q == len_q - ADDR_W'(1));
    // Only the final tuple remains in flight once the top tag bit is the
    // sole bit set.
    assign last_result = tag_q[PU_LAT-1] && (tag_q[PU_LAT-2:0] == '0);
    assign sum         = {1'b0, acc_out} + (ACC_W + 1)'(pu_out);
    assign mem_addr    = cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = (len != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                mem_rd = 1'b1;
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_result) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job length latch and issue counter; the counter stops on the last
    // tuple so mem_addr holds through DRAIN and afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (start_ok && (len != '0)) begin
            len_q <= len;
            cnt_q <= '0;
        end else if ((state_q == ISSUE) && !last_issue) begin
            cnt_q <= cnt_q + ADDR_W'(1);
        end
    end

    // Tag pipeline: a 1 marks a cycle in which a tuple was issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tag_q <= '0;
        else      tag_q <= {tag_q[PU_LAT-2:0], mem_rd};
    end

    // Saturating accumulator with sticky overflow; an accepted start clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out <= '0;
            ovf     <= 1'b0;
        end else if (start_ok) begin
            acc_out <= '0;
            ovf     <= 1'b0;
        end else if (tag_q[PU_LAT-1]) begin
            if (sum[ACC_W]) begin
                acc_out <= '1;
                ovf     <= 1'b1;
            end else begin
                acc_out <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pu_sequencer.sv
// Bench for pu_sequencer: a table of jobs run through a behavioural PU
// pipeline model, plus hand-written reset and ignored-start sequences.
module tb_pu_sequencer;

    localparam int ADDR_W = 6;
    localparam int ACC_W  = 16;
    localparam int PU_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] len_i;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       pu_out;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_base = 0;
    int cur_step = 0;

    logic [11:0] pipe [PU_LAT];

    typedef struct {
        int l;
        int base;
        int step;
        int acc;
        int ovf;
        int dcyc;
        bit poke;
    } vec_t;

    vec_t vecs [6];

    pu_sequencer #(.ADDR_W(ADDR_W), .ACC_W(ACC_W), .PU_LAT(PU_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len_i),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .pu_out   (pu_out),
        .acc_out  (acc_out),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // PU + operand memory model: tuple i yields base + step*i after PU_LAT cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PU_LAT; i++) pipe[i] <= 12'd0;
        end else begin
            pipe[0] <= mem_rd ? 12'(cur_base + cur_step * int'(mem_addr)) : 12'd0;
            for (int i = 1; i < PU_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign pu_out = pipe[PU_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int l, input int base, input int step, input int exp_acc,
                           input int exp_ovf, input int exp_done, input bit poke);
        int cyc;
        int rd;
        bit seen;
        cur_base = base;
        cur_step = step;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        start = 1'b1;
        len_i = ADDR_W'(l);
        @(posedge clk);
        #1 start = 1'b0;
        len_i = '1;
        cyc  = 1;
        rd   = 0;
        seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_c1", 64'(busy), 64'd1);
                check("acc_clear", 64'(acc_out), 64'd0);
                check("ovf_clear", 64'(ovf), 64'd0);
            end
            if (mem_rd) begin
                check("mem_addr", 64'(mem_addr), 64'(rd));
                check("rd_cycle", 64'(cyc), 64'(rd + 1));
                rd++;
            end
            if (done) begin
                seen = 1'b1;
                check("done_cycle", 64'(cyc), 64'(exp_done));
                check("acc_out", 64'(acc_out), 64'(exp_acc));
                check("ovf", 64'(ovf), 64'(exp_ovf));
            end else begin
                if (poke && (cyc == 2 || cyc == 6)) start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                cyc++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done in cycle %0d", exp_done);
        end
        check("read_count", 64'(rd), 64'(l));
        if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("poke_busy", 64'(busy), 64'd0);
            check("poke_done", 64'(done), 64'd0);
            check("poke_acc", 64'(acc_out), 64'(exp_acc));
        end
    endtask

    initial begin
        vecs[0] = '{l: 3,  base: 10,   step: 10,  acc: 60,    ovf: 0, dcyc: 6,  poke: 1'b0};
        vecs[1] = '{l: 0,  base: 0,    step: 0,   acc: 0,     ovf: 0, dcyc: 1,  poke: 1'b0};
        vecs[2] = '{l: 17, base: 4095, step: 0,   acc: 65535, ovf: 1, dcyc: 20, poke: 1'b0};
        vecs[3] = '{l: 1,  base: 5,    step: 0,   acc: 5,     ovf: 0, dcyc: 4,  poke: 1'b0};
        vecs[4] = '{l: 2,  base: 1,    step: 0,   acc: 2,     ovf: 0, dcyc: 5,  poke: 1'b0};
        vecs[5] = '{l: 4,  base: 100,  step: 100, acc: 1000,  ovf: 0, dcyc: 7,  poke: 1'b1};

        rst   = 1'b0;
        start = 1'b0;
        len_i = '0;
        #1;
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_acc", 64'(acc_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 6; v++)
            run_job(vecs[v].l, vecs[v].base, vecs[v].step, vecs[v].acc,
                    vecs[v].ovf, vecs[v].dcyc, vecs[v].poke);

        // Asynchronous reset in cycle 2 of a len=5 job.
        cur_base = 3;
        cur_step = 0;
        @(negedge clk);
        start = 1'b1;
        len_i = ADDR_W'(5);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_mem_rd", 64'(mem_rd), 64'd1);
        check("mid_mem_addr", 64'(mem_addr), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_rd", 64'(mem_rd), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_acc", 64'(acc_out), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        check("hold_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        run_job(2, 7, 1, 15, 0, 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
